// File: rtl/pc_pkg.sv
// Shared types, default vectors and helpers for the program counter unit.
package pc_pkg;

   // Redirect kind resolved each cycle, highest priority first after RD_NONE.
   typedef enum logic [2:0] {
      RD_NONE,
      RD_CALL,
      RD_BR,
      RD_RET,
      RD_IRQ,
      RD_JMP,
      RD_INC
   } redirect_e;

   localparam logic [15:0] PC_RST_VEC_DFLT = 16'h0000;
   localparam logic [15:0] PC_IRQ_VEC_DFLT = 16'h0010;

   // Ceiling log2, returns 0 for n <= 1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = (n > 0) ? n - 1 : 0; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pc_call_stack.sv
// Circular call stack with sticky overflow/underflow and saturate/wrap policy.
module pc_call_stack
   import pc_pkg::*;
#(
   parameter int unsigned AW     = 16,
   parameter int unsigned SDEPTH = 8,
   parameter int unsigned SWRAP  = 0
) (
   input  logic                   clk,
   input  logic                   RST,
   input  logic                   push,
   input  logic                   pop,
   input  logic [AW-1:0]          din,
   output logic [AW-1:0]          dout,
   output logic [clog2(SDEPTH):0] depth,
   output logic                   ovf,
   output logic                   unf
);

   localparam int unsigned PW = clog2(SDEPTH);
   localparam int unsigned DW = PW + 1;

   logic [AW-1:0] mem [SDEPTH];
   logic [PW-1:0] sp;
   logic          full_c;
   logic          wr_c;

   assign full_c = (depth == DW'(SDEPTH));
   // When full, sp points at the oldest slot, so a wrapping write overwrites it.
   assign wr_c   = push & ~RST & (~full_c | (SWRAP != 0));
   assign dout   = mem[sp - PW'(1)];

   // Entry storage, no reset needed since depth gates every read.
   always_ff @(posedge clk) begin
      if (wr_c) begin
         mem[sp] <= din;
      end
   end

   // Pointer, occupancy and sticky flags.
   always_ff @(posedge clk) begin
      if (RST) begin
         sp    <= '0;
         depth <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else if (push) begin
         if (!full_c) begin
            sp    <= sp + PW'(1);
            depth <= depth + DW'(1);
         end else begin
            ovf <= 1'b1;
            if (SWRAP != 0) begin
               sp <= sp + PW'(1);
            end
         end
      end else if (pop) begin
         if (depth != '0) begin
            sp    <= sp - PW'(1);
            depth <= depth - DW'(1);
         end else begin
            unf <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pc_unit_p.sv
// Program counter: fetch address generation, address pipeline, redirects, call stack and interrupt entry.
module pc_unit_p
   import pc_pkg::*;
#(
   parameter int unsigned   AW      = 16,
   parameter int unsigned   JW      = 13,
   parameter int unsigned   SW      = 5,
   parameter int unsigned   PIPE    = 5,
   parameter int unsigned   SDEPTH  = 8,
   parameter int unsigned   SWRAP   = 0,
   parameter logic [AW-1:0] RST_VEC = AW'(PC_RST_VEC_DFLT),
   parameter logic [AW-1:0] IRQ_VEC = AW'(PC_IRQ_VEC_DFLT)
) (
   input  logic                   clk,
   input  logic                   RST,
   input  logic                   nzt,
   input  logic                   xec,
   input  logic                   call,
   input  logic                   ret,
   input  logic                   jmp,
   input  logic                   alu_nz,
   input  logic                   hazard,
   input  logic                   branch_hazard,
   input  logic                   long_i,
   input  logic [7:0]             alu_data,
   input  logic [JW-1:0]          i_field,
   input  logic                   irq,
   output logic                   irq_ack,
   output logic [AW-1:0]          A,
   output logic [clog2(SDEPTH):0] stk_depth,
   output logic                   stk_ovf,
   output logic                   stk_unf
);

   localparam int unsigned   DW    = clog2(SDEPTH) + 1;
   localparam logic [AW-1:0] SMASK = AW'((32'd1 << SW) - 32'd1);
   localparam logic [AW-1:0] LMASK = AW'(32'hFF);

   logic [AW-1:0] pc;
   logic [AW-1:0] a_next;
   logic [AW-1:0] alt;
   logic [AW-1:0] cur;
   logic [AW-1:0] pipe  [PIPE];
   logic [7:0]    f_dly [PIPE-1];
   logic          prev_hazard;
   logic          in_isr;
   logic [DW-1:0] isr_lvl;

   redirect_e     rd_c;
   logic          irq_ok_c;
   logic [AW-1:0] br_mask_c;
   logic [AW-1:0] br_tgt_c;
   logic [AW-1:0] a_nxt_c;
   logic [AW-1:0] pc_nxt_c;
   logic          push_c;
   logic          pop_c;
   logic [AW-1:0] push_din_c;
   logic [AW-1:0] stk_top_c;

   // Address pipeline: replays the in-flight fetch after a stall, then shifts.
   always_ff @(posedge clk) begin
      if (RST) begin
         a_next      <= '0;
         alt         <= '0;
         cur         <= '0;
         prev_hazard <= 1'b0;
         for (int i = 0; i < PIPE; i++) pipe[i] <= '0;
         for (int i = 0; i < PIPE - 1; i++) f_dly[i] <= '0;
      end else begin
         a_next      <= A;
         prev_hazard <= hazard;
         if (hazard && !prev_hazard) begin
            alt <= a_next;
         end
         if (!hazard) begin
            cur     <= prev_hazard ? alt : a_next;
            pipe[0] <= cur;
         end
         for (int i = 1; i < PIPE; i++) pipe[i] <= pipe[i-1];
         f_dly[0] <= i_field[7:0];
         for (int i = 1; i < PIPE - 1; i++) f_dly[i] <= f_dly[i-1];
      end
   end

   // Redirect selection and next fetch/PC values.
   always_comb begin
      rd_c       = RD_NONE;
      a_nxt_c    = A;
      pc_nxt_c   = pc;
      push_c     = 1'b0;
      pop_c      = 1'b0;
      push_din_c = pc;
      irq_ok_c   = (SWRAP != 0) || (stk_depth != DW'(SDEPTH));
      br_mask_c  = long_i ? LMASK : SMASK;
      br_tgt_c   = (pipe[PIPE-1] & ~br_mask_c) | (AW'(alu_data) & br_mask_c);

      if (call)                                        rd_c = RD_CALL;
      else if ((nzt && alu_nz) || xec)                 rd_c = RD_BR;
      else if (ret && !branch_hazard)                  rd_c = RD_RET;
      else if (irq && !in_isr && !hazard && irq_ok_c)  rd_c = RD_IRQ;
      else if (jmp)                                    rd_c = RD_JMP;
      else if (!hazard)                                rd_c = RD_INC;

      case (rd_c)
         RD_CALL: begin
            a_nxt_c    = AW'({alu_data, f_dly[PIPE-2]});
            pc_nxt_c   = a_nxt_c;
            push_c     = 1'b1;
            push_din_c = pipe[PIPE-2];
         end
         RD_BR: begin
            a_nxt_c  = br_tgt_c;
            pc_nxt_c = xec ? pipe[PIPE-1] : br_tgt_c;
         end
         RD_RET: begin
            pop_c    = 1'b1;
            a_nxt_c  = (stk_depth == '0) ? RST_VEC : stk_top_c;
            pc_nxt_c = a_nxt_c;
         end
         RD_IRQ: begin
            push_c     = 1'b1;
            push_din_c = pc;
            a_nxt_c    = IRQ_VEC;
            pc_nxt_c   = IRQ_VEC;
         end
         RD_JMP: begin
            a_nxt_c  = {pipe[0][AW-1:JW], i_field};
            pc_nxt_c = a_nxt_c;
         end
         RD_INC: begin
            a_nxt_c  = pc + AW'(1);
            pc_nxt_c = a_nxt_c;
         end
         default: begin
            a_nxt_c  = A;
            pc_nxt_c = pc;
         end
      endcase
   end

   // Fetch address, PC and interrupt tracking registers.
   always_ff @(posedge clk) begin
      if (RST) begin
         A       <= RST_VEC;
         pc      <= RST_VEC;
         irq_ack <= 1'b0;
         in_isr  <= 1'b0;
         isr_lvl <= '0;
      end else begin
         A       <= a_nxt_c;
         pc      <= pc_nxt_c;
         irq_ack <= (rd_c == RD_IRQ);
         if (rd_c == RD_IRQ) begin
            in_isr  <= 1'b1;
            isr_lvl <= stk_depth;
         end else if (pop_c && in_isr && (stk_depth != '0) &&
                      ((stk_depth - DW'(1)) == isr_lvl)) begin
            in_isr <= 1'b0;
         end
      end
   end

   pc_call_stack #(
      .AW     (AW),
      .SDEPTH (SDEPTH),
      .SWRAP  (SWRAP)
   ) u_stk (
      .clk   (clk),
      .RST   (RST),
      .push  (push_c),
      .pop   (pop_c),
      .din   (push_din_c),
      .dout  (stk_top_c),
      .depth (stk_depth),
      .ovf   (stk_ovf),
      .unf   (stk_unf)
   );

endmodule

// File: tb/tb_pc_unit_p.sv
// Directed bench for pc_unit_p: saturating (dut0) and wrapping (dut1) stack variants.
module tb_pc_unit_p;

   logic        clk = 1'b0;
   logic        RST;
   logic        nzt, xec, call, ret, jmp, alu_nz, hazard, branch_hazard, long_i, irq;
   logic [7:0]  alu_data;
   logic [12:0] i_field;

   logic [15:0] a0, a1;
   logic        ack0, ack1, ovf0, ovf1, unf0, unf1;
   logic [3:0]  dep0, dep1;

   int total = 0;
   int bad   = 0;

   // Control bits: {hazard, jmp, nzt, alu_nz, xec, long_i}
   typedef struct {
      logic [5:0]  ctl;
      logic [12:0] ifl;
      logic [15:0] ea;
   } vec_t;

   vec_t        tbl [$];
   logic [15:0] sat_exp  [9];
   logic [15:0] wrap_exp [9];

   always #5 clk = ~clk;

   pc_unit_p dut0 (
      .clk(clk), .RST(RST), .nzt(nzt), .xec(xec), .call(call), .ret(ret), .jmp(jmp),
      .alu_nz(alu_nz), .hazard(hazard), .branch_hazard(branch_hazard), .long_i(long_i),
      .alu_data(alu_data), .i_field(i_field), .irq(irq), .irq_ack(ack0), .A(a0),
      .stk_depth(dep0), .stk_ovf(ovf0), .stk_unf(unf0)
   );

   pc_unit_p #(.SWRAP(1)) dut1 (
      .clk(clk), .RST(RST), .nzt(nzt), .xec(xec), .call(call), .ret(ret), .jmp(jmp),
      .alu_nz(alu_nz), .hazard(hazard), .branch_hazard(branch_hazard), .long_i(long_i),
      .alu_data(alu_data), .i_field(i_field), .irq(irq), .irq_ack(ack1), .A(a1),
      .stk_depth(dep1), .stk_ovf(ovf1), .stk_unf(unf1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      nzt = 1'b0; xec = 1'b0; call = 1'b0; ret = 1'b0; jmp = 1'b0; alu_nz = 1'b0;
      hazard = 1'b0; branch_hazard = 1'b0; long_i = 1'b0; irq = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp_v);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp_v);
      end
   endtask

   task automatic add(input logic [5:0] ctl, input logic [12:0] ifl, input logic [15:0] ea);
      vec_t v;
      v.ctl = ctl;
      v.ifl = ifl;
      v.ea  = ea;
      tbl.push_back(v);
   endtask

   // jmp to 0x140, seven fetches so 0x140 reaches the last pipe stage, then the branch row.
   task automatic add_blk(input logic [5:0] br_ctl, input logic [15:0] e_br, input logic [15:0] e_after);
      add(6'b010000, 13'h140, 16'h0140);
      for (int i = 1; i <= 7; i++) add(6'b000000, 13'h140, 16'(16'h0140 + i));
      add(br_ctl, 13'h140, e_br);
      add(6'b000000, 13'h140, e_after);
   endtask

   initial begin
      clr();
      RST = 1'b1;
      alu_data = 8'h00;
      i_field  = 13'h0;
      sat_exp  = '{16'h1000, 16'h0308, 16'h0307, 16'h0306, 16'h0305,
                   16'h0304, 16'h0303, 16'h0302, 16'h0000};
      wrap_exp = '{16'h1100, 16'h1000, 16'h0308, 16'h0307, 16'h0306,
                   16'h0305, 16'h0304, 16'h0303, 16'h0000};

      // Reset state
      repeat (2) tick();
      chk("rst A", a0, 16'h0000);
      chk("rst depth", 16'(dep0), 16'h0);
      chk1("rst ovf", ovf0, 1'b0);
      chk1("rst unf", unf0, 1'b0);
      chk1("rst ack", ack0, 1'b0);
      RST = 1'b0;

      // Sequential fetch then a 3-cycle stall at A=5
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk($sformatf("inc A%0d", i), a0, 16'(i));
      end
      hazard = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("stall hold %0d", i), a0, 16'h0005);
      end
      hazard = 1'b0;
      tick();
      chk("release A", a0, 16'h0006);
      tick();
      chk("replay pipe0", dut0.pipe[0], 16'h0004);
      tick();
      chk("track pipe0", dut0.pipe[0], 16'h0005);

      // Branch / execute vectors
      alu_data = 8'hFF;
      add_blk(6'b001100, 16'h015F, 16'h0160);
      add_blk(6'b001101, 16'h01FF, 16'h0200);
      add_blk(6'b000010, 16'h015F, 16'h0141);
      add_blk(6'b001000, 16'h0148, 16'h0149);
      foreach (tbl[i]) begin
         {hazard, jmp, nzt, alu_nz, xec, long_i} = tbl[i].ctl;
         i_field = tbl[i].ifl;
         tick();
         chk($sformatf("vec%0d A0", i), a0, tbl[i].ea);
         chk($sformatf("vec%0d A1", i), a1, tbl[i].ea);
      end
      clr();

      // CALL then RET, with a blocked RET first
      jmp = 1'b1; i_field = 13'h100;
      tick();
      chk("call jmp", a0, 16'h0100);
      jmp = 1'b0; i_field = 13'h034;
      repeat (8) tick();
      chk("call base", a0, 16'h0108);
      call = 1'b1; alu_data = 8'h12;
      tick();
      call = 1'b0;
      chk("call A", a0, 16'h1234);
      chk("call depth", 16'(dep0), 16'h1);
      repeat (2) tick();
      chk("call inc", a0, 16'h1236);
      ret = 1'b1; branch_hazard = 1'b1;
      tick();
      chk("ret blocked A", a0, 16'h1237);
      chk("ret blocked depth", 16'(dep0), 16'h1);
      branch_hazard = 1'b0;
      tick();
      ret = 1'b0;
      chk("ret A", a0, 16'h0102);
      chk("ret depth", 16'(dep0), 16'h0);
      chk1("ret ovf", ovf0, 1'b0);

      // Nine nested calls into an 8-entry stack, then nine returns
      jmp = 1'b1; i_field = 13'h300;
      tick();
      jmp = 1'b0;
      repeat (8) tick();
      chk("ovf base", a0, 16'h0308);
      for (int k = 0; k < 9; k++) begin
         call = 1'b1; alu_data = 8'(8'h10 + k);
         tick();
         chk($sformatf("ovf call%0d A", k), a0, 16'(16'h1000 + 16'h0100 * k));
         chk($sformatf("ovf call%0d dep0", k), 16'(dep0), 16'((k < 8) ? k + 1 : 8));
         chk($sformatf("ovf call%0d dep1", k), 16'(dep1), 16'((k < 8) ? k + 1 : 8));
         if (k == 7) chk1("ovf early", ovf0, 1'b0);
      end
      call = 1'b0;
      chk1("ovf sat", ovf0, 1'b1);
      chk1("ovf wrap", ovf1, 1'b1);
      chk1("unf before", unf0, 1'b0);
      for (int k = 0; k < 9; k++) begin
         ret = 1'b1;
         tick();
         chk($sformatf("sat ret%0d", k), a0, sat_exp[k]);
         chk($sformatf("wrap ret%0d", k), a1, wrap_exp[k]);
      end
      ret = 1'b0;
      chk1("unf sat", unf0, 1'b1);
      chk1("unf wrap", unf1, 1'b1);
      chk("unf depth", 16'(dep0), 16'h0);
      tick();
      chk1("ovf sticky", ovf0, 1'b1);

      // Interrupt entry, ignore while in service, return, re-entry, call beats irq
      jmp = 1'b1; i_field = 13'h020;
      tick();
      jmp = 1'b0;
      chk("irq base", a0, 16'h0020);
      irq = 1'b1;
      tick();
      chk("irq A", a0, 16'h0010);
      chk1("irq ack", ack0, 1'b1);
      chk("irq depth", 16'(dep0), 16'h1);
      tick();
      chk("irq2 A", a0, 16'h0011);
      chk1("irq2 ack", ack0, 1'b0);
      irq = 1'b0;
      tick();
      chk("isr inc", a0, 16'h0012);
      ret = 1'b1;
      tick();
      ret = 1'b0;
      chk("isr ret A", a0, 16'h0020);
      chk("isr ret depth", 16'(dep0), 16'h0);
      irq = 1'b1;
      tick();
      irq = 1'b0;
      chk("irq again A", a0, 16'h0010);
      chk1("irq again ack", ack0, 1'b1);
      ret = 1'b1;
      tick();
      ret = 1'b0;
      chk("irq again ret", a0, 16'h0020);
      call = 1'b1; irq = 1'b1; alu_data = 8'h05;
      tick();
      call = 1'b0;
      chk("call+irq A", a0, 16'h0520);
      chk1("call+irq ack", ack0, 1'b0);
      chk("call+irq depth", 16'(dep0), 16'h1);
      tick();
      irq = 1'b0;
      chk("irq nested A", a0, 16'h0010);
      chk("irq nested depth", 16'(dep0), 16'h2);

      // Reset in the middle of an ISR with a call pending
      RST = 1'b1; call = 1'b1;
      tick();
      chk("mid rst A", a0, 16'h0000);
      chk("mid rst depth", 16'(dep0), 16'h0);
      chk("mid rst depth1", 16'(dep1), 16'h0);
      chk1("mid rst ovf", ovf0, 1'b0);
      chk1("mid rst unf", unf0, 1'b0);
      chk1("mid rst ack", ack0, 1'b0);
      RST = 1'b0; call = 1'b0;
      tick();
      chk("post rst A", a0, 16'h0001);
      irq = 1'b1;
      tick();
      irq = 1'b0;
      chk("post rst irq A", a0, 16'h0010);
      chk1("post rst irq ack", ack0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
